ppa_bk_pipe_adder: RTL

Pipelined, parametrised Brent-Kung parallel-prefix adder/subtractor with a valid/ready stream interface and a multi-beat carry-chain mode. Operands wider than `WIDTH` are added as successive beats. The block is the registered, streaming successor to the team's fixed-width combinational prefix adders. It sits between operand-producing datapaths and accumulator/ALU consumers that need one result per clock at high frequency.

---
 rtl/ppa_bk_pipe_adder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ppa_bk_pipe_adder.sv
// ppa_bk_pipe_adder: pipelined Brent-Kung parallel-prefix adder/subtractor
// with a valid/ready stream interface and a multi-beat carry-chain mode.
// Optional build macro PPA_BK_OVF_EN adds a registered signed-overflow flag;
// without it out_ovf is tied to 0 and no overflow logic exists.
module ppa_bk_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic             in_chain,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  // Up-sweep has LU levels, down-sweep LU-1; they are split over the
  // combinational segments that follow each intermediate register.
  localparam int LU   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int NLVL = 2 * LU - 1;
  localparam int NSEG = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;

  typedef struct packed {
    logic             v;
    logic             sub;
    logic             chain;
    logic             cin;
    logic [WIDTH-1:0] p;   // bitwise propagate, needed for the final sum
    logic [WIDTH-1:0] g;   // group generate being built up
    logic [WIDTH-1:0] gp;  // group propagate being built up
  } beat_t;

  // Distance between combined nodes on a given prefix level.
  function automatic int span_of(input int lvl);
    return (lvl < LU) ? (1 << lvl) : (1 << (2 * LU - 2 - lvl));
  endfunction

  // Applies Brent-Kung levels lo..hi-1 (up-sweep first, then down-sweep).
  // A node is rewritten only from nodes that are not targets on the same
  // level, so working from the previous level's copy is exact.
  function automatic beat_t apply_levels(input beat_t b, input int lo, input int hi);
    beat_t r;
    beat_t n;
    int    span;
    int    j;
    r = b;
    for (int l = 0; l < NLVL; l++) begin
      if (l >= lo && l < hi) begin
        span = span_of(l);
        n    = r;
        for (int i = 0; i < WIDTH; i++) begin
          j = i - span;
          if (j >= 0 && (((l < LU) && (((i + 1) % (2 * span)) == 0)) ||
                         ((l >= LU) && (((i + 1) % (2 * span)) == span)))) begin
            n.g[i]  = r.g[i] | (r.gp[i] & r.g[j]);
            n.gp[i] = r.gp[i] & r.gp[j];
          end
        end
        r = n;
      end
    end
    return r;
  endfunction

  beat_t            stage_reg [NREG];
  beat_t            seg_out [STAGES];
  beat_t            head_beat;
  beat_t            last_beat;
  logic [WIDTH-1:0] b_eff;
  logic             stall;
  logic             cin_eff;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_next;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_sum_reg;
  logic             out_cout_reg;
  logic             chain_c_reg;

  // One global stall: the whole pipe freezes while the output is blocked.
  assign stall    = out_valid_reg && !out_ready;
  assign in_ready = !stall;

  // Operand conditioning, then the prefix levels owned by each segment.
  always_comb begin
    b_eff           = in_sub ? ~in_b : in_b;
    head_beat.v     = in_valid;
    head_beat.sub   = in_sub;
    head_beat.chain = in_chain;
    head_beat.cin   = in_cin;
    head_beat.p     = in_a ^ b_eff;
    head_beat.g     = in_a & b_eff;
    head_beat.gp    = in_a ^ b_eff;
    seg_out[0]      = apply_levels(head_beat, 0, (STAGES == 1) ? NLVL : 0);
    for (int k = 1; k < STAGES; k++) begin
      seg_out[k] = apply_levels(stage_reg[k-1], ((k - 1) * NLVL) / NSEG, (k * NLVL) / NSEG);
    end
  end

  // Last stage: prefixes were formed with carry-in 0, so the real carry-in
  // is injected through each bit's group propagate.
  assign last_beat = seg_out[STAGES-1];
  assign cin_eff   = last_beat.chain ? chain_c_reg : (last_beat.sub ? 1'b1 : last_beat.cin);
  assign carry[0]  = cin_eff;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_carry
      assign carry[gi+1] = last_beat.g[gi] | (last_beat.gp[gi] & cin_eff);
    end
  endgenerate

  assign sum_next = carry[WIDTH-1:0] ^ last_beat.p;

  // Intermediate pipeline registers, held as a block during a stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) stage_reg[k] <= '0;
    end else if (!stall && (STAGES > 1)) begin
      for (int k = 0; k < NREG; k++) stage_reg[k] <= seg_out[k];
    end
  end

  // Output register; the chain carry follows each beat as it is written,
  // so consumer stalls never disturb the chained carry order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_cout_reg  <= 1'b0;
      chain_c_reg   <= 1'b0;
    end else if (!stall) begin
      out_valid_reg <= last_beat.v;
      if (last_beat.v) begin
        out_sum_reg  <= sum_next;
        out_cout_reg <= carry[WIDTH];
        chain_c_reg  <= carry[WIDTH];
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_cout  = out_cout_reg;

`ifdef PPA_BK_OVF_EN
  logic out_ovf_reg;

  // Signed overflow of the same beat, aligned with out_sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_ovf_reg <= 1'b0;
    end else if (!stall && last_beat.v) begin
      out_ovf_reg <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  assign out_ovf = out_ovf_reg;
`else
  assign out_ovf = 1'b0;
`endif

endmodule
